// File: rtl/overdrive_pkg.sv
// overdrive_pkg: shared fixed-point types, gain FSM states and saturation helper for drive effects
package overdrive_pkg;
  localparam int FXP_SIZE = 32;
  localparam int BPL = 12;
  typedef logic signed [FXP_SIZE-1:0] fxp_t;
  typedef logic signed [2*FXP_SIZE-1:0] prod_t;
  localparam fxp_t UNITY = fxp_t'(1) << BPL;
  typedef enum logic [1:0] {SETTLED, RAMP_UP, RAMP_DOWN} gain_state_e;
  function automatic fxp_t sat_fxp(input prod_t prod, input prod_t limit);
    return prod > limit ? fxp_t'(limit) : prod < -limit ? fxp_t'(-limit) : fxp_t'(prod);
  endfunction
endpackage

// File: rtl/fixed_multiply.sv
// fixed_multiply: full-width signed fixed-point product rescaled by an arithmetic right shift
module fixed_multiply #(
  parameter int W = 32,
  parameter int FRAC = 12
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] p
);
  logic signed [2*W-1:0] a_x, b_x;
  assign a_x = {{W{a[W-1]}}, a};
  assign b_x = {{W{b[W-1]}}, b};
  assign p = (a_x * b_x) >>> FRAC;
endmodule

// File: rtl/gain_slew_ctrl.sv
// gain_slew_ctrl: slews a gain register toward a clamped target by a bounded step per enabled cycle
module gain_slew_ctrl
  import overdrive_pkg::*;
#(
  parameter int W = 32,
  parameter logic [W-1:0] STEP = 16,
  parameter logic [W-1:0] MAX = 65536,
  parameter logic [W-1:0] INIT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_en,
  input  logic [W-1:0] target,
  output logic [W-1:0] gain,
  output logic         settled
);
  logic [W-1:0] tgt, diff, gain_n;
  logic up;
  gain_state_e state, state_n;
  // next gain steps toward the clamped target, snapping when within one step; state classifies the result
  always_comb begin
    tgt = target > MAX ? MAX : target;
    up = tgt > gain;
    diff = up ? tgt - gain : gain - tgt;
    gain_n = !step_en ? gain : diff <= STEP ? tgt : up ? gain + STEP : gain - STEP;
    state_n = gain_n == tgt ? SETTLED : tgt > gain_n ? RAMP_UP : RAMP_DOWN;
  end
  // gain and ramp state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gain <= INIT;
      state <= SETTLED;
    end else begin
      gain <= gain_n;
      state <= state_n;
    end
  end
  assign settled = state == SETTLED;
endmodule

// File: rtl/overdrive_pregain.sv
// overdrive_pregain: slewed drive gain and output saturation ahead of the overdrive soft-clipper
module overdrive_pregain
  import overdrive_pkg::*;
#(
  parameter int bits_per_level = BPL,
  parameter int fxp_size = FXP_SIZE,
  parameter int RAMP_STEP = 16,
  parameter int MAX_GAIN_LEVELS = 16,
  parameter int SAT_LEVELS = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic signed [fxp_size-1:0] i_sample,
  input  logic [fxp_size-1:0]        i_gain_target,
  input  logic                       i_bypass,
  output logic                       o_valid,
  output logic signed [fxp_size-1:0] o_sample,
  output logic                       o_gain_settled
);
  localparam logic [fxp_size-1:0] UNITY_GAIN = fxp_size'(1) << bits_per_level;
  localparam logic [fxp_size-1:0] MAX_GAIN = fxp_size'(MAX_GAIN_LEVELS) << bits_per_level;
  localparam logic signed [2*fxp_size-1:0] SAT_LIMIT = (2*fxp_size)'(SAT_LEVELS) << bits_per_level;
  logic [fxp_size-1:0] gain;
  logic s1_valid, s1_bypass;
  logic signed [fxp_size-1:0] s1_sample, s1_gain;
  logic signed [2*fxp_size-1:0] prod;
  gain_slew_ctrl #(
    .W(fxp_size),
    .STEP(fxp_size'(RAMP_STEP)),
    .MAX(MAX_GAIN),
    .INIT(UNITY_GAIN)
  ) u_slew (
    .clk(i_clk),
    .rst(i_reset),
    .step_en(i_valid),
    .target(i_gain_target),
    .gain(gain),
    .settled(o_gain_settled)
  );
  fixed_multiply #(
    .W(fxp_size),
    .FRAC(bits_per_level)
  ) u_mul (
    .a(s1_sample),
    .b(s1_gain),
    .p(prod)
  );
  // valid pipeline; reset drops anything in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      o_valid <= s1_valid;
    end
  end
  // stage 1 captures the sample with the gain held before this cycle's step
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      s1_sample <= i_sample;
      s1_gain <= $signed(gain);
      s1_bypass <= i_bypass;
    end
  end
  // stage 2 drives scaled/saturated or bypassed sample, holding between valids
  always_ff @(posedge i_clk) begin
    if (i_reset) o_sample <= '0;
    else if (s1_valid) o_sample <= s1_bypass ? s1_sample : sat_fxp(prod, SAT_LIMIT);
  end
endmodule

// File: tb/tb_overdrive_pregain.sv
// tb_overdrive_pregain: randomized scoreboard bench with a behavioural gain/saturation model
module tb_overdrive_pregain;
  logic clk = 1'b0;
  logic i_reset, i_valid, i_bypass;
  logic signed [31:0] i_sample;
  logic [31:0] i_gain_target;
  logic o_valid, o_gain_settled;
  logic signed [31:0] o_sample;
  int compared = 0;
  int mism = 0;
  int unsigned g = 4096;
  logic [31:0] exp_q[$];

  overdrive_pregain dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_valid(i_valid),
    .i_sample(i_sample),
    .i_gain_target(i_gain_target),
    .i_bypass(i_bypass),
    .o_valid(o_valid),
    .o_sample(o_sample),
    .o_gain_settled(o_gain_settled)
  );

  always #5 clk = ~clk;

  function automatic int unsigned clampt(input logic [31:0] t);
    return t > 32'd65536 ? 65536 : int'(t);
  endfunction

  function automatic int unsigned next_gain(input int unsigned gv, input int unsigned t);
    if (gv == t) return gv;
    if ((t > gv ? t - gv : gv - t) <= 16) return t;
    return t > gv ? gv + 16 : gv - 16;
  endfunction

  function automatic logic [31:0] sat_ref(input logic [31:0] s, input int unsigned gv);
    longint p;
    p = (longint'($signed(s)) * longint'(gv)) >>> 12;
    if (p > 32768) p = 32768;
    else if (p < -32768) p = -32768;
    return 32'(p);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mism++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] s, input bit byp);
    i_valid = v;
    i_sample = s;
    i_bypass = byp;
    @(posedge clk);
    if (v) begin
      exp_q.push_back(byp ? s : sat_ref(s, g));
      g = next_gain(g, clampt(i_gain_target));
    end
    #1;
    chk("settled", 32'(o_gain_settled), 32'(g == clampt(i_gain_target)));
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    exp_q.delete();
    g = 4096;
    chk("reset_settled", 32'(o_gain_settled), 32'd1);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_sample", o_sample, 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 32'(o_valid), 32'd0);
        else chk("sample", o_sample, exp_q.pop_front());
      end
    end
  end

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_bypass = 1'b0;
    i_sample = '0;
    i_gain_target = 32'd4096;
    do_reset();
    do_reset();
    step(1'b1, 32'h800, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    i_gain_target = 32'd8192;
    for (int i = 0; i < 300; i++) step(1'b1, 32'h1000, 1'b0);
    i_gain_target = 32'd32768;
    for (int i = 0; i < 1600; i++) step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h2000, 1'b0);
    step(1'b1, -32'sh2000, 1'b0);
    step(1'b1, 32'h7000_0000, 1'b1);
    step(1'b1, 32'h7000_0000, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    i_gain_target = 32'd4096;
    for (int i = 0; i < 1800; i++) step(1'b1, 32'h0, 1'b0);
    i_gain_target = 32'd8192;
    for (int i = 0; i < 120; i++) step(1'b1, 32'h1000, 1'b0);
    step(1'b1, 32'h1234, 1'b0);
    step(1'b1, 32'h4321, 1'b0);
    do_reset();
    i_gain_target = 32'd4096;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h1000, 1'b0);
    i_gain_target = 32'h00FF_FFFF;
    for (int i = 0; i < 3900; i++) begin
      step(1'b1, 32'h800, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0);
    end
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) i_gain_target = $urandom_range(0, 80000);
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 1) ? 32'($urandom) : 32'($urandom_range(0, 32'h20000)) - 32'h10000,
           $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
